// File: rtl/saturn_fetch_if.sv
// Saturn fetch-stage signal bundle: decoder control, nibble memory bus and decoder feed.
// The master modport is the fetch stage; the slave modport is its environment.
interface saturn_fetch_if;
  logic        i_stall;
  logic        i_jump;
  logic [19:0] i_jump_addr;
  logic        o_bus_req;
  logic [19:0] o_bus_addr;
  logic        i_bus_ack;
  logic [3:0]  i_bus_nibble;
  logic [3:0]  o_nibble;
  logic [19:0] o_nibble_pc;
  logic        o_en_dec;
  logic [31:0] o_cycles;

  modport master (
    input  i_stall, i_jump, i_jump_addr, i_bus_ack, i_bus_nibble,
    output o_bus_req, o_bus_addr, o_nibble, o_nibble_pc, o_en_dec, o_cycles
  );

  modport slave (
    output i_stall, i_jump, i_jump_addr, i_bus_ack, i_bus_nibble,
    input  o_bus_req, o_bus_addr, o_nibble, o_nibble_pc, o_en_dec, o_cycles
  );
endinterface

// File: rtl/saturn_fetch.sv
// Saturn nibble fetch stage: req/ack nibble bus into a prefetch FIFO feeding the decoder.
// Define SATURN_FETCH_CYCLES_EN to build the free-running 32-bit cycle counter on o_cycles.
module saturn_fetch #(
  parameter int          DEPTH    = 4,
  parameter logic [19:0] RESET_PC = 20'h00000
) (
  input logic            i_clk,
  input logic            i_reset_n,
  saturn_fetch_if.master bus
);
  localparam int            AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {S_BOOT, S_FETCH, S_REDIRECT} state_t;

  state_t        r_state, w_state_nxt;
  logic [19:0]   r_addr;
  logic [AW-1:0] r_wptr, r_rptr;
  logic [AW:0]   r_count;
  logic [3:0]    r_nib_mem [DEPTH];
  logic [19:0]   r_pc_mem  [DEPTH];
  logic          w_req, w_push, w_pop, w_empty;

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_pop       = 1'b0;
    w_empty     = (r_count == '0);
    case (r_state)
      S_BOOT:     w_state_nxt = S_FETCH;
      S_FETCH: begin
        // A redirect suppresses both the request and the pop in its own cycle.
        w_req = (r_count < FULL) && !bus.i_jump;
        w_pop = !w_empty && !bus.i_stall && !bus.i_jump;
        if (bus.i_jump) w_state_nxt = S_REDIRECT;
      end
      S_REDIRECT: w_state_nxt = bus.i_jump ? S_REDIRECT : S_FETCH;
      default:    w_state_nxt = S_BOOT;
    endcase
    w_push = w_req && bus.i_bus_ack;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_state <= S_BOOT;
      r_addr  <= RESET_PC;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (bus.i_jump) begin
        r_addr  <= bus.i_jump_addr;
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_addr <= r_addr + 20'd1;
          r_wptr <= r_wptr + AW'(1);
        end
        if (w_pop) r_rptr <= r_rptr + AW'(1);
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + (AW + 1)'(1);
          2'b01:   r_count <= r_count - (AW + 1)'(1);
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage carries no reset; emptiness is tracked solely by r_count.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_nib_mem[r_wptr] <= bus.i_bus_nibble;
      r_pc_mem[r_wptr]  <= r_addr;
    end
  end

  assign bus.o_bus_req   = w_req;
  assign bus.o_bus_addr  = r_addr;
  assign bus.o_en_dec    = w_pop;
  assign bus.o_nibble    = w_empty ? 4'h0 : r_nib_mem[r_rptr];
  assign bus.o_nibble_pc = w_empty ? r_addr : r_pc_mem[r_rptr];

`ifdef SATURN_FETCH_CYCLES_EN
  logic [31:0] r_cycles;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) r_cycles <= 32'h0;
    else            r_cycles <= r_cycles + 32'd1;
  end

  assign bus.o_cycles = r_cycles;
`else
  assign bus.o_cycles = 32'h0;
`endif
endmodule

// File: tb/tb_saturn_fetch.sv
// Scoreboard bench for saturn_fetch: a queue-based FIFO model predicts bus and decoder
// behaviour each cycle; a separate monitor checks every delivered nibble against the scoreboard.
module tb_saturn_fetch;
  localparam int          DEPTH    = 4;
  localparam logic [19:0] RESET_PC = 20'h00000;

  typedef struct packed {
    logic [19:0] pc;
    logic [3:0]  nib;
  } ent_t;

  logic clk = 1'b0;
  logic rst_n;
  saturn_fetch_if sif ();

  saturn_fetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .i_clk    (clk),
    .i_reset_n(rst_n),
    .bus      (sif)
  );

  always #5 clk = ~clk;

  // Memory model: mem[a] = a[3:0], answering whatever address is on the bus.
  assign sif.i_bus_nibble = sif.o_bus_addr[3:0];

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  ent_t        mq[$];
  ent_t        sb[$];
  bit          m_boot  = 1'b1;
  bit          m_redir = 1'b0;
  logic [19:0] m_addr  = RESET_PC;
  logic [31:0] m_cycles = 32'h0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] exp_cycles(input logic [31:0] c);
`ifdef SATURN_FETCH_CYCLES_EN
    return c;
`else
    return 32'h0;
`endif
  endfunction

  // Reference model: compares this cycle's outputs, then advances to the next edge.
  always @(negedge clk) begin
    bit   exp_req, exp_en;
    ent_t e;
    if (!rst_n) begin
      m_boot = 1'b1; m_redir = 1'b0; m_addr = RESET_PC; m_cycles = 32'h0;
      mq.delete(); sb.delete();
      chk("rst_bus_req", sif.o_bus_req, 1'b0);
      chk("rst_en_dec", sif.o_en_dec, 1'b0);
      chk("rst_nibble", sif.o_nibble, 4'h0);
      chk("rst_nibble_pc", sif.o_nibble_pc, RESET_PC);
      chk("rst_bus_addr", sif.o_bus_addr, RESET_PC);
      chk("rst_cycles", sif.o_cycles, 32'h0);
    end else begin
      exp_req = !m_boot && !m_redir && (mq.size() < DEPTH) && !sif.i_jump;
      exp_en  = !m_boot && !m_redir && (mq.size() > 0) && !sif.i_stall && !sif.i_jump;
      chk("bus_req", sif.o_bus_req, exp_req);
      chk("en_dec", sif.o_en_dec, exp_en);
      chk("bus_addr", sif.o_bus_addr, m_addr);
      chk("head_pc", sif.o_nibble_pc, (mq.size() > 0) ? mq[0].pc : m_addr);
      chk("head_nibble", sif.o_nibble, (mq.size() > 0) ? mq[0].nib : 4'h0);
      chk("cycles", sif.o_cycles, exp_cycles(m_cycles));
      if (exp_en) begin
        e = mq.pop_front();
        sb.push_back(e);
      end
      if (exp_req && sif.i_bus_ack) begin
        mq.push_back('{pc: m_addr, nib: m_addr[3:0]});
        m_addr = m_addr + 20'd1;
      end
      if (sif.i_jump) begin
        mq.delete();
        m_addr = sif.i_jump_addr;
      end
      m_redir  = !m_boot && sif.i_jump;
      m_boot   = 1'b0;
      m_cycles = m_cycles + 32'd1;
    end
  end

  // Monitor: every nibble handed to the decoder must be the next scoreboard entry.
  always @(negedge clk) begin
    ent_t e;
    #2;
    if (rst_n && sif.o_en_dec) begin
      if (sb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL sb_underflow: got unexpected nibble %0h at pc %0h, expected none",
                 sif.o_nibble, sif.o_nibble_pc);
      end else begin
        e = sb.pop_front();
        chk("dec_nibble", sif.o_nibble, e.nib);
        chk("dec_pc", sif.o_nibble_pc, e.pc);
      end
    end
  end

  task automatic drive(input bit s, input bit a, input bit j, input logic [19:0] ja);
    @(posedge clk);
    #1;
    sif.i_stall = s; sif.i_bus_ack = a; sif.i_jump = j; sif.i_jump_addr = ja;
  endtask

  initial begin
    rst_n = 1'b0;
    sif.i_stall = 1'b0; sif.i_jump = 1'b0; sif.i_jump_addr = '0; sif.i_bus_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Zero-wait streaming from reset
    repeat (30) drive(1'b0, 1'b1, 1'b0, 20'h0);
    // Stall with ack always: fills to DEPTH, then drains and refills
    repeat (10) drive(1'b1, 1'b1, 1'b0, 20'h0);
    repeat (20) drive(1'b0, 1'b1, 1'b0, 20'h0);
    // Jump with a partly full FIFO
    drive(1'b1, 1'b1, 1'b0, 20'h0);
    drive(1'b0, 1'b1, 1'b1, 20'h12345);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 20'h0);
    // Address wrap at the top of the space
    drive(1'b0, 1'b1, 1'b1, 20'hFFFFE);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 20'h0);
    // Back-to-back jumps, stall during a jump
    drive(1'b0, 1'b1, 1'b1, 20'h0ABCD);
    drive(1'b1, 1'b1, 1'b1, 20'h54321);
    repeat (10) drive(1'b0, 1'b1, 1'b0, 20'h0);

    for (int i = 0; i < 400; i++)
      drive(($urandom % 4) == 0, ($urandom % 3) != 0, ($urandom % 20) == 0, 20'($urandom));

    // Asynchronous reset in the middle of a burst
    repeat (5) drive(1'b0, 1'b1, 1'b0, 20'h0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_bus_req", sif.o_bus_req, 1'b0);
    chk("async_en_dec", sif.o_en_dec, 1'b0);
    chk("async_nibble", sif.o_nibble, 4'h0);
    chk("async_nibble_pc", sif.o_nibble_pc, RESET_PC);
    chk("async_bus_addr", sif.o_bus_addr, RESET_PC);
    chk("async_cycles", sif.o_cycles, 32'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (15) drive(1'b0, 1'b1, 1'b0, 20'h0);
    repeat (3) drive(1'b0, 1'b0, 1'b0, 20'h0);
    @(posedge clk);
    #4;
    chk("sb_drained", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/saturn_fetch.md
# saturn_fetch

Nibble fetch stage for the Saturn core, directly upstream of `saturn_decoder`. It holds the 20-bit fetch address and runs a req/ack nibble bus toward memory. Fetched nibbles are buffered in a small prefetch FIFO. The decoder receives one nibble per cycle as `o_nibble` qualified by `o_en_dec`, along with its address and the free-running cycle count that feeds the decoder's `i_cycles`.

## Interface
- `DEPTH`, 4: prefetch FIFO depth in nibbles; power of two, 2..16.
- `RESET_PC`, 20'h00000: fetch address after reset.
- `i_clk`  in  1  single clock; all state updates on the rising edge.
- `i_reset_n`  in  1  reset, asynchronous, active-low.
- `i_stall`  in  1  decoder cannot accept a nibble this cycle.
- `i_jump`  in  1  redirect pulse; flush and refetch from `i_jump_addr`.
- `i_jump_addr`  in  20  new fetch address, sampled when `i_jump`=1.
- `o_bus_req`  out  1  nibble read request.
- `o_bus_addr`  out  20  nibble address; stable while `o_bus_req`=1 and not acked.
- `i_bus_ack`  in  1  memory returns `i_bus_nibble` this cycle.
- `i_bus_nibble`  in  4  read data, valid when `o_bus_req`&&`i_bus_ack`.
- `o_nibble`  out  4  FIFO head nibble; 0 when FIFO empty.
- `o_nibble_pc`  out  20  address of `o_nibble`.
- `o_en_dec`  out  1  decoder enable: head valid and consumed this cycle.
- `o_cycles`  out  32  cycle counter (see Configuration).

## Operation
- The FSM has three states:
  - S_BOOT: entered on reset. No request. Moves unconditionally to S_FETCH after one cycle.
  - S_FETCH: normal operation. `i_jump` moves it to S_REDIRECT.
  - S_REDIRECT: lasts one cycle. Request low, FIFO empty. Moves to S_FETCH, or stays in S_REDIRECT if `i_jump` is asserted again.
- `o_bus_req` = (state==S_FETCH) && (count<DEPTH) && !`i_jump`. This is combinational from registered state and count plus `i_jump`.
- Transfer occurs when `o_bus_req`&&`i_bus_ack`:
  - `i_bus_nibble` and `o_bus_addr` are pushed as one FIFO entry.
  - `o_bus_addr` increments by 1, mod 2^20; 20'hFFFFF wraps to 20'h00000.
- `o_en_dec` = (count>0) && !`i_stall` && !`i_jump` && state==S_FETCH. Pop occurs when `o_en_dec`=1.
- Push and pop in the same cycle leave count unchanged. The pointers each advance, mod DEPTH.
- When full, the request stays low that cycle even if a pop occurs. A refill is requested the next cycle.
- `i_jump` (any state except reset):
  - The FIFO is flushed: count 0, pointers 0.
  - `o_bus_addr` <= `i_jump_addr`.
  - An ack in the same cycle is ignored, because request is forced low.
  - No pop occurs.
- `i_stall` during a jump has no effect; the jump wins.
- `o_nibble_pc` is the address stored with the head entry. When the FIFO is empty it equals `o_bus_addr`.
- Reset mid-transfer drops any in-flight ack. The memory side must tolerate an abandoned request.

## Timing
- Values while `i_reset_n`=0:
  - state S_BOOT, `o_bus_req` 0, `o_bus_addr` RESET_PC;
  - `o_en_dec` 0, `o_nibble` 0, `o_nibble_pc` RESET_PC;
  - `o_cycles` 0, FIFO empty.
- After reset release at edge R: S_FETCH from R+1, so the first request is visible in cycle R+1.
- Fill latency: an ack in cycle N gives `o_en_dec`=1 in cycle N+1, unless stalled.
- Jump latency: jump in cycle N gives S_REDIRECT in N+1 and a request at the new address in N+2. An ack in N+2 gives the earliest `o_en_dec` in N+3.
- With zero-wait memory and no stalls, throughput is 1 nibble/cycle.
- Back-to-back jumps: the last one wins. Each jump extends S_REDIRECT by one cycle.

## Configuration
- `SATURN_FETCH_CYCLES_EN` defined:
  - `o_cycles` is a 32-bit counter, 0 in reset, incremented every clock.
  - It wraps 32'hFFFFFFFF to 0.
- `SATURN_FETCH_CYCLES_EN` undefined:
  - no counter register;
  - `o_cycles` is tied to 32'h0.

## Test plan
- Reset, then ack every cycle from a memory model (mem[a]=a[3:0]), no stall:
  - `o_bus_req` first in R+1;
  - `o_en_dec` from R+2 with nibbles 0,1,2,3…;
  - `o_nibble_pc` 0,1,2…
- Hold `i_stall`=1 with ack always:
  - exactly DEPTH pushes, then `o_bus_req` 0;
  - releasing the stall drains in order and refills with no lost or duplicated nibble.
- Jump to 20'h12345 while the FIFO is half full:
  - no `o_en_dec` in N, N+1, N+2;
  - first nibble in N+3 has `o_nibble_pc`=20'h12345.
- Start at 20'hFFFFE: fetch addresses FFFFE, FFFFF, 00000, 00001.
- Assert `i_reset_n` low mid-burst with ack high:
  - all outputs reach their reset values immediately, without waiting for a clock edge;
  - the FIFO is empty after release.
- With the macro defined, `o_cycles`=10 at the 10th edge after release; undefined, it is constantly 0.
